// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter that drives the select code of the four-input source mux.
// One grantee at a time; tenure ends on done, request drop or hold limit.
module rr_sel_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [3:0] sel,
  output logic       valid
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  localparam logic [3:0] CNT_LAST = 4'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q,   sel_d;
  logic       valid_q, valid_d;
  logic [1:0] last_q,  last_d;
  logic [3:0] cnt_q,   cnt_d;

  logic [2:0] pick;
  logic       rel;
  logic       arb;

  // Returns {found, index}; search starts just after the last winner so it
  // is visited last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    last_d  = last_q;
    cnt_d   = cnt_q;

    pick = rr_pick(req, last_q);
    rel  = (state_q == S_GRANT) && (done || !req[sel_q] || (cnt_q == CNT_LAST));
    arb  = (state_q == S_IDLE) || rel;

    if (state_q == S_GRANT && !rel) begin
      cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 4'd1;
    end

    // last_q always equals the current grantee, so a release re-arbitrates
    // with the outgoing source at lowest priority.
    if (arb) begin
      cnt_d = 4'd0;
      if (pick[2]) begin
        state_d = S_GRANT;
        grant_d = 4'd1 << pick[1:0];
        sel_d   = pick[1:0];
        valid_d = 1'b1;
        last_d  = pick[1:0];
      end else begin
        state_d = S_IDLE;
        grant_d = 4'd0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= 4'd0;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
      last_q  <= 2'd3;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant = grant_q;
  assign sel   = {2'b00, sel_q};
  assign valid = valid_q;

endmodule
